// File: rtl/rng_window_checker.sv
// -----------------------------------------------------------------------------
// rng_window_checker
//
// Sink-side quality checker for 16-bit random number generators. It collects a
// fixed window of WINDOW samples over a valid/ready handshake. For the window it
// computes the total ones count, the unsigned min/max and the number of
// back-to-back repeats. It then reports a registered pass/fail verdict.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         begin a new window (honoured only in IDLE)
//   sample_valid  sample_in holds a generator sample
//   sample_in     generator sample
//   sample_ready  checker accepts a sample this cycle (COLLECT only)
//   busy          high in COLLECT and REPORT
//   done          one-cycle pulse, results valid
//   ones_count    total set bits across the window
//   min_val       smallest sample (unsigned)
//   max_val       largest sample (unsigned)
//   repeat_count  samples equal to the immediately preceding accepted sample
//   pass          ones_count within [ONES_LO, ONES_HI] and no repeats
// -----------------------------------------------------------------------------
module rng_window_checker #(
  parameter int WIDTH   = 16,
  parameter int WINDOW  = 200,
  parameter int ONES_LO = 1500,
  parameter int ONES_HI = 1700,
  localparam int CW = $clog2(WIDTH * WINDOW + 1),
  localparam int NW = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  output logic             sample_ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    ones_count,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic [NW-1:0]    repeat_count,
  output logic             pass
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  // Number of set bits in one sample, widened to the accumulator width.
  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  state_t           state_r;
  logic             sample_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [CW-1:0]    ones_count_r;
  logic [WIDTH-1:0] min_val_r;
  logic [WIDTH-1:0] max_val_r;
  logic [NW-1:0]    repeat_count_r;
  logic [NW-1:0]    cnt_r;
  logic [WIDTH-1:0] prev_r;

  logic             accept_s;
  logic             first_s;
  logic             last_s;
  logic             rep_hit_s;
  logic [CW-1:0]    ones_next_s;
  logic [NW-1:0]    rep_next_s;
  logic             pass_next_s;

  // Per-accept next values; pass is evaluated on the post-update totals so it
  // can be registered on the same edge that accepts the final sample.
  always_comb begin
    accept_s    = 1'b0;
    first_s     = 1'b0;
    last_s      = 1'b0;
    rep_hit_s   = 1'b0;
    ones_next_s = ones_count_r;
    rep_next_s  = repeat_count_r;
    pass_next_s = 1'b0;
    if ((state_r == COLLECT) && sample_valid && sample_ready_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    first_s     = (cnt_r == '0);
    last_s      = (cnt_r == NW'(WINDOW - 1));
    if (!first_s && (sample_in == prev_r)) begin
      rep_hit_s = 1'b1;
    end else begin
      rep_hit_s = 1'b0;
    end
    ones_next_s = ones_count_r + popcount(sample_in);
    rep_next_s  = repeat_count_r + NW'(rep_hit_s);
    if ((ones_next_s >= CW'(ONES_LO)) && (ones_next_s <= CW'(ONES_HI)) &&
        (rep_next_s == '0)) begin
      pass_next_s = 1'b1;
    end else begin
      pass_next_s = 1'b0;
    end
  end

  // Control FSM with registered outputs and window statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      sample_ready_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
      ones_count_r   <= '0;
      min_val_r      <= '0;
      max_val_r      <= '0;
      repeat_count_r <= '0;
      cnt_r          <= '0;
      prev_r         <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r        <= COLLECT;
            sample_ready_r <= 1'b1;
            busy_r         <= 1'b1;
            ones_count_r   <= '0;
            repeat_count_r <= '0;
            cnt_r          <= '0;
          end else begin
            sample_ready_r <= 1'b0;
            busy_r         <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept_s) begin
            cnt_r          <= cnt_r + NW'(1);
            ones_count_r   <= ones_next_s;
            repeat_count_r <= rep_next_s;
            prev_r         <= sample_in;
            // First sample seeds min/max; later ones compare unsigned.
            if (first_s || (sample_in < min_val_r)) begin
              min_val_r <= sample_in;
            end
            if (first_s || (sample_in > max_val_r)) begin
              max_val_r <= sample_in;
            end
            if (last_s) begin
              state_r        <= REPORT;
              sample_ready_r <= 1'b0;
              done_r         <= 1'b1;
              pass_r         <= pass_next_s;
            end
          end
        end
        REPORT: begin
          state_r        <= IDLE;
          done_r         <= 1'b0;
          busy_r         <= 1'b0;
          sample_ready_r <= 1'b0;
        end
        default: begin
          state_r        <= IDLE;
          sample_ready_r <= 1'b0;
          busy_r         <= 1'b0;
          done_r         <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready = sample_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign ones_count   = ones_count_r;
  assign min_val      = min_val_r;
  assign max_val      = max_val_r;
  assign repeat_count = repeat_count_r;

endmodule

// File: tb/tb_rng_window_checker.sv
// Directed bench for rng_window_checker (WIDTH=16, WINDOW=200).
module tb_rng_window_checker;

  localparam int CW = 12;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          sample_valid = 1'b0;
  logic [15:0]   sample_in = 16'h0000;
  logic          sample_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] ones_count;
  logic [15:0]   min_val;
  logic [15:0]   max_val;
  logic [NW-1:0] repeat_count;
  logic          pass;

  int checks = 0;
  int errors = 0;

  rng_window_checker #(
    .WIDTH(16), .WINDOW(200), .ONES_LO(1500), .ONES_HI(1700)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample_in(sample_in), .sample_ready(sample_ready), .busy(busy),
    .done(done), .ones_count(ones_count), .min_val(min_val),
    .max_val(max_val), .repeat_count(repeat_count), .pass(pass)
  );

  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until it is accepted (bounded wait).
  task automatic send(input logic [15:0] v);
    int n;
    n = 0;
    sample_valid = 1'b1;
    sample_in    = v;
    while (sample_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (n >= 8) begin
      checks++; errors++;
      $display("FAIL send_timeout: sample_ready=%b required 1", sample_ready);
    end
    tick();
    sample_valid = 1'b0;
  endtask

  // Pulse start from IDLE; afterwards the checker must be collecting.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (sample_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: ready=%b busy=%b required 1 1", sample_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({sample_ready, busy, done, pass} !== 4'b0000 || ones_count !== 12'd0 ||
        min_val !== 16'd0 || max_val !== 16'd0 || repeat_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b pass=%b ones=%0d min=%h max=%h rep=%0d required all 0",
               sample_ready, busy, done, pass, ones_count, min_val, max_val, repeat_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b ready=%b required 0 0", busy, sample_ready);
    end
  endtask

  task automatic test_stuck();
    do_start();
    for (int i = 0; i < 200; i++) send(16'h0000);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL stuck_done: done=%b busy=%b rdy=%b required 1 1 0", done, busy, sample_ready);
    end
    checks++;
    if (ones_count !== 12'd0 || min_val !== 16'h0000 || max_val !== 16'h0000 ||
        repeat_count !== 8'd199 || pass !== 1'b0) begin
      errors++;
      $display("FAIL stuck_results: ones=%0d min=%h max=%h rep=%0d pass=%b required 0 0000 0000 199 0",
               ones_count, min_val, max_val, repeat_count, pass);
    end
  endtask

  // start during REPORT is ignored; start in the following IDLE cycle is taken.
  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || repeat_count !== 8'd199) begin
      errors++;
      $display("FAIL report_start_ignored: done=%b busy=%b rep=%0d required 0 0 199", done, busy, repeat_count);
    end
    do_start();
    for (int i = 0; i < 100; i++) begin
      send(16'hAAAA);
      send(16'h5555);
    end
    checks++;
    if (done !== 1'b1 || ones_count !== 12'd1600 || min_val !== 16'h5555 ||
        max_val !== 16'hAAAA || repeat_count !== 8'd0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL alternation: done=%b ones=%0d min=%h max=%h rep=%0d pass=%b required 1 1600 5555 aaaa 0 1",
               done, ones_count, min_val, max_val, repeat_count, pass);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ones_count !== 12'd1600 || pass !== 1'b1) begin
      errors++;
      $display("FAIL alternation_hold: done=%b busy=%b ones=%0d pass=%b required 0 0 1600 1",
               done, busy, ones_count, pass);
    end
  endtask

  task automatic test_ramp_gaps();
    do_start();
    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 2) tick();
      send(16'(i));
    end
    checks++;
    if (done !== 1'b1 || ones_count !== 12'd732 || min_val !== 16'd0 ||
        max_val !== 16'd199 || repeat_count !== 8'd0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL ramp: done=%b ones=%0d min=%0d max=%0d rep=%0d pass=%b required 1 732 0 199 0 0",
               done, ones_count, min_val, max_val, repeat_count, pass);
    end
    tick();
  endtask

  task automatic test_lcg();
    logic [15:0] x;
    logic [15:0] s;
    logic [15:0] prev;
    logic [15:0] mn;
    logic [15:0] mx;
    int          ones;
    int          reps;
    int          cyc;
    logic        exp_pass;
    x = 16'h1234; ones = 0; reps = 0; mn = 16'hFFFF; mx = 16'h0000; prev = 16'h0000;
    sample_valid = 1'b1;
    start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      x = x * 16'd25173 + 16'd13849;
      s = x;
      sample_in = s;
      ones += $countones(s);
      if (s < mn) mn = s;
      if (s > mx) mx = s;
      if (i > 0 && s == prev) reps++;
      prev = s;
      tick();
      cyc++;
      start = 1'b0;
      if (i == 0) begin
        // First edge took the start; present the same first sample again.
        tick();
        cyc++;
      end
    end
    sample_valid = 1'b0;
    exp_pass = (ones >= 1500 && ones <= 1700 && reps == 0);
    checks++;
    if (done !== 1'b1 || cyc !== 201) begin
      errors++;
      $display("FAIL lcg_latency: done=%b after %0d edges required 1 after 201", done, cyc);
    end
    checks++;
    if (ones_count !== 12'(ones) || min_val !== mn || max_val !== mx ||
        repeat_count !== 8'(reps) || pass !== exp_pass) begin
      errors++;
      $display("FAIL lcg_results: ones=%0d min=%h max=%h rep=%0d pass=%b required %0d %h %h %0d %b",
               ones_count, min_val, max_val, repeat_count, pass, ones, mn, mx, reps, exp_pass);
    end
    tick();
  endtask

  task automatic test_start_in_collect();
    do_start();
    for (int i = 0; i < 100; i++) begin
      if (i == 25) start = 1'b1;
      send(16'hAAAA);
      start = 1'b0;
      send(16'h5555);
    end
    checks++;
    if (done !== 1'b1 || ones_count !== 12'd1600 || repeat_count !== 8'd0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL start_in_collect: done=%b ones=%0d rep=%0d pass=%b required 1 1600 0 1",
               done, ones_count, repeat_count, pass);
    end
    tick();
  endtask

  task automatic test_reset_mid_window();
    do_start();
    for (int i = 0; i < 120; i++) send(16'h00FF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({sample_ready, busy, done, pass} !== 4'b0000 || ones_count !== 12'd0 ||
        min_val !== 16'd0 || max_val !== 16'd0 || repeat_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b busy=%b done=%b pass=%b ones=%0d min=%h max=%h rep=%0d required all 0",
               sample_ready, busy, done, pass, ones_count, min_val, max_val, repeat_count);
    end
    do_start();
    for (int i = 0; i < 200; i++) send(16'hFFFF);
    checks++;
    if (done !== 1'b1 || ones_count !== 12'd3200 || min_val !== 16'hFFFF ||
        max_val !== 16'hFFFF || repeat_count !== 8'd199 || pass !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_ffff: done=%b ones=%0d min=%h max=%h rep=%0d pass=%b required 1 3200 ffff ffff 199 0",
               done, ones_count, min_val, max_val, repeat_count, pass);
    end
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_stuck();
    test_back_to_back();
    test_ramp_gaps();
    test_lcg();
    test_start_in_collect();
    test_reset_mid_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
